seq_alu: RTL and testbench

//   Parametrised multi-cycle ALU; the next generation of the 3-bit-opcode combinational ALU.

---
 rtl/seq_alu_if.sv | 27 ++
 rtl/seq_alu.sv | 181 ++++++++++++++++++
 tb/tb_seq_alu.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu.
// The master drives operations and accepts results; the slave is the ALU.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       ALUOp;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] D;
  logic             dz;
  logic             busy;

  modport master (
    output in_valid, A, B, ALUOp, out_ready,
    input  in_ready, out_valid, C, D, dz, busy
  );

  modport slave (
    input  in_valid, A, B, ALUOp, out_ready,
    output in_ready, out_valid, C, D, dz, busy
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle add/sub/and/or/srl/sra plus iterative
// shift-add multiply and restoring divide, one operation in flight.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  seq_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_SRL  = 3'd4;
  localparam logic [2:0] OP_SRA  = 3'd5;
  localparam logic [2:0] OP_MULU = 3'd6;
  localparam logic [2:0] OP_DIVU = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             dz_q, dz_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  function automatic logic [WIDTH-1:0] simple_result(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      OP_ADD:  simple_result = a + b;
      OP_SUB:  simple_result = a - b;
      OP_AND:  simple_result = a & b;
      OP_OR:   simple_result = a | b;
      OP_SRL:  simple_result = a >> sh;
      OP_SRA:  simple_result = $unsigned($signed(a) >>> sh);
      default: simple_result = '0;
    endcase
  endfunction

  // One iteration step; {hi,lo} is the product pair for mulu and {remainder,quotient} for divu.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, b_q};
    if (is_div_q) begin
      if (!div_trial[WIDTH]) begin
        step_hi = div_trial[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Next-state and datapath register update.
  always_comb begin
    state_d     = state_q;
    is_div_d    = is_div_q;
    b_d         = b_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    c_d         = c_q;
    d_d         = d_q;
    dz_d        = dz_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (bus.ALUOp == OP_MULU || (bus.ALUOp == OP_DIVU && bus.B != '0)) begin
            state_d  = S_CALC;
            is_div_d = (bus.ALUOp == OP_DIVU);
            b_d      = bus.B;
            hi_d     = '0;
            lo_d     = bus.A;
            cnt_d    = '0;
          end else if (bus.ALUOp == OP_DIVU) begin
            state_d = S_DONE;
            c_d     = '1;
            d_d     = bus.A;
            dz_d    = 1'b1;
          end else begin
            state_d = S_DONE;
            c_d     = simple_result(bus.ALUOp, bus.A, bus.B);
            d_d     = '0;
            dz_d    = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + SHW'(1'b1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          c_d     = step_lo;
          d_d     = step_hi;
          dz_d    = 1'b0;
        end else begin
          state_d = S_CALC;
        end
      end
      S_DONE: begin
        // out_valid rises one cycle after entering DONE so results are registered before exposure.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      is_div_q    <= 1'b0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      c_q         <= '0;
      d_q         <= '0;
      dz_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_div_q    <= is_div_d;
      b_q         <= b_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      c_q         <= c_d;
      d_q         <= d_d;
      dz_q        <= dz_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q == S_CALC);
  assign bus.out_valid = out_valid_q;
  assign bus.C         = c_q;
  assign bus.D         = d_q;
  assign bus.dz        = dz_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed vector bench for seq_alu at WIDTH=32 and WIDTH=8.
module tb_seq_alu;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  seq_alu_if #(.WIDTH(32)) i32 ();
  seq_alu_if #(.WIDTH(8))  i8 ();

  seq_alu #(.WIDTH(32)) u32 (.clk(clk), .reset(reset), .bus(i32.slave));
  seq_alu #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(i8.slave));

  always #5 clk = ~clk;

  typedef struct {
    bit          w8;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic        dz;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one op, count edges until out_valid, capture the result, then hand it off.
  task automatic run_op(input bit w8, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] c, output logic [31:0] d, output logic dz);
    if (w8) begin
      i8.in_valid = 1'b1; i8.ALUOp = op; i8.A = a[7:0]; i8.B = b[7:0];
    end else begin
      i32.in_valid = 1'b1; i32.ALUOp = op; i32.A = a; i32.B = b;
    end
    @(posedge clk); #1;
    i8.in_valid  = 1'b0;
    i32.in_valid = 1'b0;
    lat = 0;
    while (!(w8 ? i8.out_valid : i32.out_valid) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    c  = w8 ? {24'h0, i8.C} : i32.C;
    d  = w8 ? {24'h0, i8.D} : i32.D;
    dz = w8 ? i8.dz : i32.dz;
    i8.out_ready  = 1'b1;
    i32.out_ready = 1'b1;
    @(posedge clk); #1;
    i8.out_ready  = 1'b0;
    i32.out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    int          busy_cnt;
    logic [31:0] c, d;
    logic        dz;

    vecs.push_back('{1'b0, 3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b0, 1,  "add_wrap"});
    vecs.push_back('{1'b0, 3'd1, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 32'h0, 1'b0, 1,  "sub_neg"});
    vecs.push_back('{1'b0, 3'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0, 1'b0, 1,  "and"});
    vecs.push_back('{1'b0, 3'd3, 32'h12340000, 32'h00005678, 32'h12345678, 32'h0, 1'b0, 1,  "or"});
    vecs.push_back('{1'b0, 3'd5, 32'h80000000, 32'h00000004, 32'hF8000000, 32'h0, 1'b0, 1,  "sra4"});
    vecs.push_back('{1'b0, 3'd4, 32'h80000000, 32'h00000004, 32'h08000000, 32'h0, 1'b0, 1,  "srl4"});
    vecs.push_back('{1'b0, 3'd4, 32'h80000000, 32'h00000025, 32'h04000000, 32'h0, 1'b0, 1,  "srl_b25"});
    vecs.push_back('{1'b0, 3'd5, 32'h80000000, 32'h00000025, 32'hFC000000, 32'h0, 1'b0, 1,  "sra_b25"});
    vecs.push_back('{1'b0, 3'd5, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 32'h0, 1'b0, 1,  "sra31_neg"});
    vecs.push_back('{1'b0, 3'd5, 32'h7FFFFFFF, 32'h0000001F, 32'h00000000, 32'h0, 1'b0, 1,  "sra31_pos"});
    vecs.push_back('{1'b0, 3'd4, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 32'h0, 1'b0, 1,  "srl0"});
    vecs.push_back('{1'b0, 3'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 33, "mul_max"});
    vecs.push_back('{1'b0, 3'd6, 32'h12345678, 32'h00000010, 32'h23456780, 32'h00000001, 1'b0, 33, "mul_x16"});
    vecs.push_back('{1'b0, 3'd6, 32'h00000000, 32'hABCDEF01, 32'h00000000, 32'h00000000, 1'b0, 33, "mul_zero"});
    vecs.push_back('{1'b0, 3'd7, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 33, "div_100_7"});
    vecs.push_back('{1'b0, 3'd7, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 1,  "div_by0"});
    vecs.push_back('{1'b0, 3'd7, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 33, "div_by1"});
    vecs.push_back('{1'b0, 3'd7, 32'd3,        32'd10,       32'd0,        32'd3,        1'b0, 33, "div_small"});
    vecs.push_back('{1'b0, 3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, "div_big"});
    vecs.push_back('{1'b1, 3'd0, 32'hFF, 32'h01, 32'h00, 32'h00, 1'b0, 1, "w8_add_wrap"});
    vecs.push_back('{1'b1, 3'd1, 32'h03, 32'h05, 32'hFE, 32'h00, 1'b0, 1, "w8_sub_neg"});
    vecs.push_back('{1'b1, 3'd5, 32'h80, 32'h04, 32'hF8, 32'h00, 1'b0, 1, "w8_sra4"});
    vecs.push_back('{1'b1, 3'd4, 32'h80, 32'h04, 32'h08, 32'h00, 1'b0, 1, "w8_srl4"});
    vecs.push_back('{1'b1, 3'd5, 32'h80, 32'h25, 32'hFC, 32'h00, 1'b0, 1, "w8_sra_b25"});
    vecs.push_back('{1'b1, 3'd4, 32'h80, 32'h25, 32'h04, 32'h00, 1'b0, 1, "w8_srl_b25"});
    vecs.push_back('{1'b1, 3'd6, 32'hFF, 32'hFF, 32'h01, 32'hFE, 1'b0, 9, "w8_mul_max"});
    vecs.push_back('{1'b1, 3'd7, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 9, "w8_div_100_7"});
    vecs.push_back('{1'b1, 3'd7, 32'd5,   32'd0, 32'hFF, 32'd5, 1'b1, 1, "w8_div_by0"});

    i32.in_valid = 1'b0; i32.A = '0; i32.B = '0; i32.ALUOp = 3'd0; i32.out_ready = 1'b0;
    i8.in_valid  = 1'b0; i8.A  = '0; i8.B  = '0; i8.ALUOp  = 3'd0; i8.out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_out_valid", 32'(i32.out_valid), 32'd0);
    check("rst_C",         i32.C,              32'd0);
    check("rst_D",         i32.D,              32'd0);
    check("rst_dz",        32'(i32.dz),        32'd0);
    check("rst_busy",      32'(i32.busy),      32'd0);
    check("rst_in_ready",  32'(i32.in_ready),  32'd1);

    foreach (vecs[i]) begin
      run_op(vecs[i].w8, vecs[i].op, vecs[i].a, vecs[i].b, lat, c, d, dz);
      check({vecs[i].name, " lat"}, 32'(lat), 32'(vecs[i].lat));
      check({vecs[i].name, " C"},   c,        vecs[i].c);
      check({vecs[i].name, " D"},   d,        vecs[i].d);
      check({vecs[i].name, " dz"},  32'(dz),  32'(vecs[i].dz));
      check({vecs[i].name, " in_ready_after"}, 32'(vecs[i].w8 ? i8.in_ready : i32.in_ready), 32'd1);
    end

    // busy must be high for exactly WIDTH cycles of a multiply
    i32.in_valid = 1'b1; i32.ALUOp = 3'd6; i32.A = 32'hFFFFFFFF; i32.B = 32'hFFFFFFFF;
    @(posedge clk); #1;
    i32.in_valid = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      if (i32.busy) busy_cnt++;
      if (i32.out_valid) break;
      @(posedge clk); #1;
    end
    check("mul_busy_cycles", 32'(busy_cnt), 32'd32);
    check("mul_busy_done_valid", 32'(i32.out_valid), 32'd1);
    i32.out_ready = 1'b1;
    @(posedge clk); #1;
    i32.out_ready = 1'b0;

    // result held under back-pressure while new requests are ignored
    i32.in_valid = 1'b1; i32.ALUOp = 3'd0; i32.A = 32'd1; i32.B = 32'd2;
    @(posedge clk); #1;
    i32.in_valid = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      i32.in_valid = k[0];
      i32.A = 32'h1000 + 32'(k);
      i32.B = ~32'(k);
      i32.ALUOp = 3'(k);
      check("hold_out_valid", 32'(i32.out_valid), 32'd1);
      check("hold_C",         i32.C,              32'd3);
      check("hold_in_ready",  32'(i32.in_ready),  32'd0);
      @(posedge clk); #1;
    end
    i32.in_valid  = 1'b0;
    i32.out_ready = 1'b1;
    @(posedge clk); #1;
    i32.out_ready = 1'b0;
    check("release_in_ready",  32'(i32.in_ready),  32'd1);
    check("release_out_valid", 32'(i32.out_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("no_queued_op", 32'(i32.out_valid), 32'd0);

    // reset in the middle of a multiply drops it
    i32.in_valid = 1'b1; i32.ALUOp = 3'd6; i32.A = 32'h12345678; i32.B = 32'h9ABCDEF0;
    @(posedge clk); #1;
    i32.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_out_valid", 32'(i32.out_valid), 32'd0);
    check("midrst_C",         i32.C,              32'd0);
    check("midrst_D",         i32.D,              32'd0);
    check("midrst_in_ready",  32'(i32.in_ready),  32'd1);
    check("midrst_busy",      32'(i32.busy),      32'd0);
    run_op(1'b0, 3'd0, 32'd7, 32'd8, lat, c, d, dz);
    check("post_rst_add lat", 32'(lat), 32'd1);
    check("post_rst_add C",   c,        32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
